// File: rtl/tick_sched_pkg.sv
// Shared types and helpers for the tick scheduler and datapath sequencers.
package tick_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_BURST = 2'd2,
        S_DRAIN = 2'd3
    } tick_state_t;

    // Smallest divisor that still yields a distinct high and low phase.
    localparam int unsigned MIN_DIV = 2;

    // Clamp a requested divisor to MIN_DIV; callers zero-extend to 64 bits and truncate back.
    function automatic logic [63:0] div_clamp(input logic [63:0] d);
        return (d < 64'(MIN_DIV)) ? 64'(MIN_DIV) : d;
    endfunction

endpackage

// File: rtl/tick_sched_counter.sv
// Period counter with registered tick and square-wave outputs.
// Outputs are computed from next-cycle count/divisor so they line up with the count
// they describe while still coming straight from flops.
module tick_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_en,        // scheduler active this cycle
    input  logic             i_en_next,   // scheduler active next cycle
    input  logic [CNT_W-1:0] i_div_next,  // divisor in force next cycle
    output logic             o_wrap,      // this cycle is the last of a period
    output logic             o_tick,
    output logic             o_clk
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_d;
    logic             r_tick;
    logic             r_clk;

    // Next count: held at zero while idle, restarts after the last cycle of a period.
    always_comb begin
        w_count_d = r_count + CNT_W'(1);
        if (!i_en || !i_en_next || r_tick) begin
            w_count_d = '0;
        end
    end

    // Count register plus lookahead tick/clk flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
            r_tick  <= 1'b0;
            r_clk   <= 1'b0;
        end else begin
            r_count <= w_count_d;
            r_tick  <= i_en_next && (w_count_d == (i_div_next - CNT_W'(1)));
            r_clk   <= i_en_next && (w_count_d < (i_div_next >> 1));
        end
    end

    assign o_wrap = r_tick;
    assign o_tick = r_tick;
    assign o_clk  = r_clk;

endmodule

// File: rtl/tick_sched.sv
// Runtime-programmable clock-enable scheduler: free-run or exact-count bursts of
// tick strobes, with divisor updates that only land on period boundaries.
module tick_sched
    import tick_sched_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 100_000_000,
    parameter int unsigned BURST_W     = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_valid_i,
    input  logic [CNT_W-1:0]   cfg_div_i,
    output logic               cfg_ready_o,
    input  logic               start_i,
    input  logic [BURST_W-1:0] burst_len_i,
    input  logic               stop_i,
    output logic               tick_o,
    output logic               clk_o,
    output logic               busy_o,
    output logic               done_o
);

    tick_state_t        r_state, w_state_d;
    logic [CNT_W-1:0]   r_div, w_div_d;
    logic [BURST_W-1:0] r_rem, w_rem_d;
    logic               r_pend_vld, w_pend_vld_d;
    logic [CNT_W-1:0]   r_pend_div, w_pend_div_d;
    logic               r_ready;
    logic               r_busy;
    logic               r_done, w_done_d;
    logic               w_wrap;
    logic               w_xfer;
    logic               w_apply;
    logic [CNT_W-1:0]   w_cfg_div;

    assign w_cfg_div = CNT_W'(div_clamp(64'(cfg_div_i)));

    // Mode FSM and burst countdown; a stop on the last cycle of a period ends it right there.
    always_comb begin
        w_state_d = r_state;
        w_rem_d   = r_rem;
        w_done_d  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start_i && !stop_i) begin
                    w_state_d = (burst_len_i == '0) ? S_RUN : S_BURST;
                    w_rem_d   = burst_len_i;
                end
            end
            S_RUN: begin
                if (stop_i) begin
                    w_state_d = w_wrap ? S_IDLE : S_DRAIN;
                end
            end
            S_BURST: begin
                if (w_wrap && (r_rem <= BURST_W'(1))) begin
                    w_state_d = S_IDLE;
                    w_rem_d   = '0;
                    w_done_d  = 1'b1;
                end else if (stop_i) begin
                    w_state_d = w_wrap ? S_IDLE : S_DRAIN;
                    w_rem_d   = '0;
                end else if (w_wrap) begin
                    w_rem_d = r_rem - BURST_W'(1);
                end
            end
            S_DRAIN: begin
                if (w_wrap) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_rem_d   = '0;
            end
        endcase
    end

    // Divisor handshake: one pending slot, applied immediately when idle, else at a wrap.
    always_comb begin
        w_xfer       = cfg_valid_i && r_ready;
        w_apply      = r_pend_vld && ((r_state == S_IDLE) || w_wrap);
        w_div_d      = w_apply ? r_pend_div : r_div;
        w_pend_vld_d = r_pend_vld;
        w_pend_div_d = r_pend_div;
        if (w_apply) begin
            w_pend_vld_d = 1'b0;
        end
        if (w_xfer) begin
            w_pend_vld_d = 1'b1;
            w_pend_div_d = w_cfg_div;
        end
    end

    // Control state and registered status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_div      <= CNT_W'(DEFAULT_DIV);
            r_rem      <= '0;
            r_pend_vld <= 1'b0;
            r_pend_div <= '0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_div      <= w_div_d;
            r_rem      <= w_rem_d;
            r_pend_vld <= w_pend_vld_d;
            r_pend_div <= w_pend_div_d;
            r_ready    <= !w_pend_vld_d;
            r_busy     <= (w_state_d != S_IDLE);
            r_done     <= w_done_d;
        end
    end

    tick_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_en       (r_state != S_IDLE),
        .i_en_next  (w_state_d != S_IDLE),
        .i_div_next (w_div_d),
        .o_wrap     (w_wrap),
        .o_tick     (tick_o),
        .o_clk      (clk_o)
    );

    assign cfg_ready_o = r_ready;
    assign busy_o      = r_busy;
    assign done_o      = r_done;

endmodule
